// File: rtl/cdr_sequencer.sv
// Packet-level sequencer for the BLE receive clock-recovery path: arms clock
// recovery, waits for the preamble, then walks AA/header/payload/CRC bits.
module cdr_sequencer #(
  parameter int unsigned SAMPLE_RATE    = 16,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned ARM_CYCLES     = 2,
  parameter int unsigned MAX_LEN        = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] access_addr,
  input  logic        preamble_detected,
  input  logic        symbol_clk,
  input  logic        demod_bit,
  output logic        cr_en,
  output logic        cr_resetn,
  output logic        busy,
  output logic        bit_valid,
  output logic        bit_out,
  output logic [7:0]  pdu_len,
  output logic        packet_done,
  output logic        packet_err,
  output logic [1:0]  err_code
);

  localparam int unsigned SW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned WW = $clog2(2 * SAMPLE_RATE + 1);
  localparam int unsigned AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [SW-1:0] LP_TO_M1  = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [WW-1:0] LP_WD_M1  = WW'(2 * SAMPLE_RATE - 1);
  localparam logic [AW-1:0] LP_ARM_M1 = AW'(ARM_CYCLES - 1);
  localparam logic [8:0]    LP_MAX    = 9'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_SEARCH, S_AA, S_HDR, S_PAY, S_CRC, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic [SW-1:0] r_strobe_cnt;
  logic [WW-1:0] r_wd_cnt;
  logic [AW-1:0] r_arm_cnt;
  logic [10:0] r_bit_cnt;
  logic [31:0] r_aa_sh;
  logic [7:0]  r_len_sh;
  logic        r_cr_resetn;
  logic        r_bit_valid;
  logic        r_bit_out;
  logic [7:0]  r_pdu_len;
  logic        r_packet_done;
  logic        r_packet_err;
  logic [1:0]  r_err_code;

  logic        w_acc;
  logic        w_rx;
  logic [31:0] w_aa_word;
  logic [7:0]  w_len_byte;
  logic        w_pay_last;
  logic        w_wd_expire;

  assign w_acc       = en & symbol_clk;
  assign w_rx        = r_state inside {S_AA, S_HDR, S_PAY, S_CRC};
  assign w_aa_word   = {demod_bit, r_aa_sh[31:1]};
  assign w_len_byte  = {demod_bit, r_len_sh[7:1]};
  assign w_pay_last  = (r_bit_cnt == ({r_pdu_len, 3'b000} - 11'd1));
  // A strobe carrying an accepted bit never counts toward expiry.
  assign w_wd_expire = en & ~symbol_clk & (r_wd_cnt == LP_WD_M1);

  assign cr_en       = en & (w_rx | (r_state == S_SEARCH));
  assign busy        = (r_state != S_IDLE);
  assign cr_resetn   = r_cr_resetn;
  assign bit_valid   = r_bit_valid;
  assign bit_out     = r_bit_out;
  assign pdu_len     = r_pdu_len;
  assign packet_done = r_packet_done;
  assign packet_err  = r_packet_err;
  assign err_code    = r_err_code;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_strobe_cnt  <= '0;
      r_wd_cnt      <= '0;
      r_arm_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_aa_sh       <= '0;
      r_len_sh      <= '0;
      r_cr_resetn   <= 1'b1;
      r_bit_valid   <= 1'b0;
      r_bit_out     <= 1'b0;
      r_pdu_len     <= '0;
      r_packet_done <= 1'b0;
      r_packet_err  <= 1'b0;
      r_err_code    <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state       <= S_IDLE;
      r_cr_resetn   <= 1'b1;
      r_bit_valid   <= 1'b0;
      r_packet_done <= 1'b0;
      r_packet_err  <= 1'b0;
    end else begin
      r_bit_valid   <= 1'b0;
      r_packet_done <= 1'b0;
      r_packet_err  <= 1'b0;

      if (w_rx) begin
        if (w_acc)   r_wd_cnt <= '0;
        else if (en) r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if ((r_state inside {S_HDR, S_PAY, S_CRC}) && w_acc) begin
        r_bit_valid <= 1'b1;
        r_bit_out   <= demod_bit;
      end

      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state      <= S_ARM;
            r_cr_resetn  <= 1'b0;
            r_strobe_cnt <= '0;
            r_wd_cnt     <= '0;
            r_arm_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_aa_sh      <= '0;
            r_len_sh     <= '0;
          end
        end
        S_ARM: begin
          if (r_arm_cnt == LP_ARM_M1) begin
            r_state     <= S_SEARCH;
            r_cr_resetn <= 1'b1;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end
        S_SEARCH: begin
          if (preamble_detected) begin
            r_state   <= S_AA;
            r_bit_cnt <= '0;
            r_wd_cnt  <= '0;
          end else if (en) begin
            if (r_strobe_cnt == LP_TO_M1) begin
              r_state      <= S_ERR;
              r_packet_err <= 1'b1;
              r_err_code   <= 2'd0;
            end else begin
              r_strobe_cnt <= r_strobe_cnt + 1'b1;
            end
          end
        end
        S_AA: begin
          if (w_acc) begin
            r_aa_sh <= w_aa_word;
            if (r_bit_cnt == 11'd31) begin
              r_bit_cnt <= '0;
              if (w_aa_word == access_addr) begin
                r_state <= S_HDR;
              end else begin
                r_state      <= S_ERR;
                r_packet_err <= 1'b1;
                r_err_code   <= 2'd1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_HDR: begin
          if (w_acc) begin
            if (r_bit_cnt >= 11'd8) r_len_sh <= w_len_byte;
            if (r_bit_cnt == 11'd15) begin
              r_bit_cnt <= '0;
              r_pdu_len <= w_len_byte;
              if ({1'b0, w_len_byte} > LP_MAX) begin
                r_state      <= S_ERR;
                r_packet_err <= 1'b1;
                r_err_code   <= 2'd2;
              end else if (w_len_byte == 8'd0) begin
                r_state <= S_CRC;
              end else begin
                r_state <= S_PAY;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_PAY: begin
          if (w_acc) begin
            if (w_pay_last) begin
              r_state   <= S_CRC;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (w_acc) begin
            if (r_bit_cnt == 11'd23) begin
              r_state       <= S_DONE;
              r_packet_done <= 1'b1;
              r_bit_cnt     <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Expiry implies no accepted bit this cycle, so it cannot collide with
      // a state advance from the case above.
      if (w_rx && w_wd_expire) begin
        r_state      <= S_ERR;
        r_packet_err <= 1'b1;
        r_err_code   <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_cdr_sequencer.sv
// Randomized bench for cdr_sequencer: packets are built as bit lists and the
// expected forwarded stream / outcome is derived from the packet rules.
module tb_cdr_sequencer;

  logic        clk = 1'b0;
  logic        resetn, en, start, abort, preamble_detected, symbol_clk, demod_bit;
  logic [31:0] access_addr;

  logic       cr_en, cr_resetn, busy, bit_valid, bit_out, packet_done, packet_err;
  logic [7:0] pdu_len;
  logic [1:0] err_code;
  logic       cr_en_b, cr_resetn_b, busy_b, bit_valid_b, bit_out_b, packet_done_b, packet_err_b;
  logic [7:0] pdu_len_b;
  logic [1:0] err_code_b;

  cdr_sequencer dut (
    .clk(clk), .resetn(resetn), .en(en), .start(start), .abort(abort),
    .access_addr(access_addr), .preamble_detected(preamble_detected),
    .symbol_clk(symbol_clk), .demod_bit(demod_bit),
    .cr_en(cr_en), .cr_resetn(cr_resetn), .busy(busy), .bit_valid(bit_valid),
    .bit_out(bit_out), .pdu_len(pdu_len), .packet_done(packet_done),
    .packet_err(packet_err), .err_code(err_code)
  );

  cdr_sequencer #(.MAX_LEN(37)) dut_b (
    .clk(clk), .resetn(resetn), .en(en), .start(start), .abort(abort),
    .access_addr(access_addr), .preamble_detected(preamble_detected),
    .symbol_clk(symbol_clk), .demod_bit(demod_bit),
    .cr_en(cr_en_b), .cr_resetn(cr_resetn_b), .busy(busy_b), .bit_valid(bit_valid_b),
    .bit_out(bit_out_b), .pdu_len(pdu_len_b), .packet_done(packet_done_b),
    .packet_err(packet_err_b), .err_code(err_code_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int         n_done = 0, n_err = 0, n_crlow = 0, n_err_b = 0, n_fwd_b = 0;
  logic [1:0] last_code = '0, last_code_b = '0;
  logic       fwd_q[$];

  always @(posedge clk) begin
    #1;
    if (bit_valid) fwd_q.push_back(bit_out);
    if (packet_done) n_done++;
    if (packet_err) begin n_err++; last_code = err_code; end
    if (!cr_resetn) n_crlow++;
    if (bit_valid_b) n_fwd_b++;
    if (packet_err_b) begin n_err_b++; last_code_b = err_code_b; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic e, input logic sc, input logic b);
    @(negedge clk);
    en = e; symbol_clk = sc; demod_bit = b;
    start = 1'b0; abort = 1'b0; preamble_detected = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  // Random non-accepting cycles (never more than 3 strobes) then one accepted bit.
  task automatic send_bit(input logic b);
    int gaps, kind;
    gaps = int'($urandom_range(0, 3));
    repeat (gaps) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      tick(1'b0, 1'b1, 1'($urandom));
      else if (kind == 1) tick(1'b1, 1'b0, 1'($urandom));
      else                tick(1'b0, 1'b0, 1'b0);
    end
    tick(1'b1, 1'b1, b);
  endtask

  task automatic do_start();
    tick(1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    #1;
    chk("arm_cr_en", cr_en, 1'b0);
    chk("arm_cr_resetn", cr_resetn, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic search(input int n, input logic pre);
    for (int k = 1; k <= n; k++) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      if (pre && (k == n)) preamble_detected = 1'b1;
      if (k == 1) begin
        #1;
        chk("search_cr_en", cr_en, 1'b1);
      end
    end
  endtask

  task automatic send_aa_hdr(input logic [31:0] aa, input logic [7:0] len);
    logic [15:0] hdr;
    hdr = {len, 8'($urandom)};
    for (int i = 0; i < 32; i++) send_bit(aa[i]);
    for (int i = 0; i < 16; i++) send_bit(hdr[i]);
  endtask

  task automatic good_packet(input logic [31:0] aa, input logic [7:0] len, input int pre_at);
    logic        exp_q[$];
    logic [15:0] hdr;
    logic        b;
    int base_f, base_d, base_e, base_c, base_eb, base_fb, exp_n;
    access_addr = aa;
    hdr = {len, 8'($urandom)};
    base_f = fwd_q.size(); base_d = n_done; base_e = n_err;
    base_c = n_crlow; base_eb = n_err_b; base_fb = n_fwd_b;
    do_start();
    search(pre_at, 1'b1);
    for (int i = 0; i < 32; i++) send_bit(aa[i]);
    for (int i = 0; i < 16; i++) begin send_bit(hdr[i]); exp_q.push_back(hdr[i]); end
    tick(1'b0, 1'b0, 1'b0);
    chk("b_len_err_at_hdr", n_err_b - base_eb, (len > 37) ? 1 : 0);
    if (len > 37) chk("b_err_code", last_code_b, 2);
    for (int i = 0; i < 8 * int'(len) + 24; i++) begin
      b = 1'($urandom);
      send_bit(b);
      exp_q.push_back(b);
    end
    idle(3);
    exp_n = 16 + 8 * int'(len) + 24;
    chk("fwd_count", fwd_q.size() - base_f, exp_n);
    for (int i = 0; i < exp_n; i++)
      if (base_f + i < fwd_q.size()) chk("fwd_bit", fwd_q[base_f + i], exp_q[i]);
    chk("done_count", n_done - base_d, 1);
    chk("err_count", n_err - base_e, 0);
    chk("pdu_len", pdu_len, len);
    chk("cr_resetn_low", n_crlow - base_c, 2);
    chk("busy_after", busy, 1'b0);
    chk("b_fwd_count", n_fwd_b - base_fb, (len > 37) ? 16 : exp_n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int base_e, base_f, base_d;
    logic [31:0] aa;
    resetn = 1'b0; access_addr = '0;
    en = 0; start = 0; abort = 0; preamble_detected = 0; symbol_clk = 0; demod_bit = 0;
    idle(3);
    chk("rst_busy", busy, 0);
    chk("rst_cr_resetn", cr_resetn, 1);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_pdu_len", pdu_len, 0);
    chk("rst_done_err", {packet_done, packet_err}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_cr_en", cr_en, 0);
    resetn = 1'b1;
    idle(2);

    good_packet(32'h8E89BED6, 8'd3, 100);
    good_packet(32'h8E89BED6, 8'd0, 20);
    good_packet($urandom, 8'd38, 30);
    for (int r = 0; r < 4; r++)
      good_packet($urandom, 8'($urandom_range(1, 10)), int'($urandom_range(1, 150)));

    // search timeout, then preamble on the last strobe
    base_e = n_err;
    do_start();
    search(4095, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("to_not_early", n_err - base_e, 0);
    chk("to_busy_before", busy, 1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("to_err", n_err - base_e, 1);
    chk("to_code", last_code, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("to_idle", busy, 0);

    base_e = n_err;
    do_start();
    search(4096, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk("pre_wins_err", n_err - base_e, 0);
    chk("pre_wins_busy", busy, 1);
    abort = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("abort_aa_busy", busy, 0);

    // AA mismatch in bit 31 only
    access_addr = 32'h8E89BED6;
    aa = access_addr ^ 32'h8000_0000;
    base_e = n_err; base_f = fwd_q.size();
    do_start();
    search(50, 1'b1);
    for (int i = 0; i < 31; i++) send_bit(aa[i]);
    tick(1'b0, 1'b0, 1'b0);
    chk("aa_not_early", n_err - base_e, 0);
    send_bit(aa[31]);
    tick(1'b0, 1'b0, 1'b0);
    chk("aa_err", n_err - base_e, 1);
    chk("aa_code", last_code, 1);
    chk("aa_no_fwd", fwd_q.size() - base_f, 0);

    // symbol loss after 5th payload bit
    access_addr = $urandom;
    base_e = n_err; base_f = fwd_q.size();
    do_start();
    search(10, 1'b1);
    send_aa_hdr(access_addr, 8'd4);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    for (int s = 0; s < 31; s++) begin
      tick(1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) tick(1'b0, 1'b1, 1'b1);
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("wd_not_early", n_err - base_e, 0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("wd_err", n_err - base_e, 1);
    chk("wd_code", last_code, 3);
    chk("wd_fwd", fwd_q.size() - base_f, 21);

    // abort in PAY with a simultaneous start and accepted bit
    base_e = n_err; base_f = fwd_q.size(); base_d = n_done;
    do_start();
    search(5, 1'b1);
    send_aa_hdr(access_addr, 8'd6);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    tick(1'b1, 1'b1, 1'b1);
    abort = 1'b1; start = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_bit_valid", bit_valid, 0);
    idle(3);
    chk("abort_fwd", fwd_q.size() - base_f, 26);
    chk("abort_no_pulse", (n_done - base_d) + (n_err - base_e), 0);
    chk("abort_start_ignored", busy, 0);

    // abort in ARM releases cr_resetn
    tick(1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("abort_arm_cr_resetn", cr_resetn, 1);
    chk("abort_arm_busy", busy, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("idle_start_abort", busy, 0);
    idle(2);
    chk("idle_start_abort_later", busy, 0);

    // reset mid-CRC
    do_start();
    search(5, 1'b1);
    send_aa_hdr(access_addr, 8'd1);
    for (int i = 0; i < 18; i++) send_bit(1'($urandom));
    tick(1'b1, 1'b1, 1'b1);
    resetn = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cr_resetn", cr_resetn, 1);
    chk("mid_rst_bits", {bit_valid, bit_out}, 0);
    chk("mid_rst_pdu_len", pdu_len, 0);
    chk("mid_rst_pulses", {packet_done, packet_err}, 0);
    chk("mid_rst_err_code", err_code, 0);
    resetn = 1'b1;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
